// File: rtl/register_16bit_if.sv
// Data/enable/output bundle for register_16bit.
// The master drives D/en; the register (slave) drives Q.
interface register_16bit_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] D;
  logic             en;
  logic [WIDTH-1:0] Q;

  modport master (output D, output en, input Q);
  modport slave  (input D, input en, output Q);
endinterface

// File: rtl/register_16bit.sv
// WIDTH-bit load-enabled register with synchronous active-high reset.
// Q comes straight from the flops: one-cycle load latency, no D/en-to-Q path.
module register_16bit #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  register_16bit_if.slave       bus
);

  // Reset wins over load; with en low, the whole word holds even if D is X.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.Q <= RESET_VALUE;
    end else if (bus.en) begin
      bus.Q <= bus.D;
    end
  end

endmodule

// File: tb/tb_register_16bit.sv
// Self-checking bench for register_16bit: directed scenarios plus a random run
// checked against a behavioural model of the stored word.
module tb_register_16bit;
  localparam int unsigned      W   = 16;
  localparam logic [W-1:0]     RV2 = 16'hC3A5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  register_16bit_if #(.WIDTH(W)) bus ();
  register_16bit_if #(.WIDTH(W)) bus2 ();
  assign bus2.D  = bus.D;
  assign bus2.en = bus.en;

  register_16bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  register_16bit #(.WIDTH(W), .RESET_VALUE(RV2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q;
  logic [W-1:0] exp_q2;

  // Apply inputs half a cycle before the next rising edge.
  task automatic drive(input logic r, input logic e, input logic [W-1:0] d);
    @(negedge clk);
    reset  = r;
    bus.en = e;
    bus.D  = d;
  endtask

  // Advance one rising edge, update the model from the values seen there, settle.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      exp_q  = '0;
      exp_q2 = RV2;
    end else if (bus.en) begin
      exp_q  = bus.D;
      exp_q2 = bus.D;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, W'($urandom));
    step();
    checks++;
    if (bus.Q !== 16'h0000) begin
      failures++;
      $display("FAIL reset_q got=%h exp=%h", bus.Q, 16'h0000);
    end
    checks++;
    if (bus2.Q !== RV2) begin
      failures++;
      $display("FAIL reset_q_custom got=%h exp=%h", bus2.Q, RV2);
    end
  endtask

  task automatic test_release_hold();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, W'($urandom));
      step();
      checks++;
      if (bus.Q !== 16'h0000 || bus2.Q !== RV2) begin
        failures++;
        $display("FAIL release_hold cyc=%0d got=%h/%h exp=%h/%h", i, bus.Q, bus2.Q, 16'h0000, RV2);
      end
    end
  endtask

  task automatic test_load();
    drive(1'b0, 1'b1, 16'h0003);
    step();
    checks++;
    if (bus.Q !== 16'h0003) begin
      failures++;
      $display("FAIL load got=%h exp=%h", bus.Q, 16'h0003);
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b0, 16'h0002);
    step();
    checks++;
    if (bus.Q !== 16'h0003) begin
      failures++;
      $display("FAIL hold_1 got=%h exp=%h", bus.Q, 16'h0003);
    end
    drive(1'b0, 1'b0, 16'h000D);
    step();
    checks++;
    if (bus.Q !== 16'h0003) begin
      failures++;
      $display("FAIL hold_2 got=%h exp=%h", bus.Q, 16'h0003);
    end
  endtask

  task automatic test_reset_unknown();
    drive(1'b1, 1'b0, 16'hxxxx);
    step();
    checks++;
    if (bus.Q !== 16'h0000) begin
      failures++;
      $display("FAIL reset_unknown got=%h exp=%h", bus.Q, 16'h0000);
    end
    drive(1'b0, 1'b0, 16'hxxxx);
    step();
    checks++;
    if (bus.Q !== 16'h0000 || bus2.Q !== RV2) begin
      failures++;
      $display("FAIL hold_unknown got=%h/%h exp=%h/%h", bus.Q, bus2.Q, 16'h0000, RV2);
    end
  endtask

  task automatic test_priority();
    drive(1'b0, 1'b1, 16'h7777);
    step();
    drive(1'b1, 1'b1, 16'hFFFF);
    step();
    checks++;
    if (bus.Q !== 16'h0000 || bus2.Q !== RV2) begin
      failures++;
      $display("FAIL priority got=%h/%h exp=%h/%h", bus.Q, bus2.Q, 16'h0000, RV2);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 16'hA5A5);
    step();
    checks++;
    if (bus.Q !== 16'hA5A5) begin
      failures++;
      $display("FAIL b2b_first got=%h exp=%h", bus.Q, 16'hA5A5);
    end
    drive(1'b0, 1'b1, 16'h5A5A);
    step();
    checks++;
    if (bus.Q !== 16'h5A5A) begin
      failures++;
      $display("FAIL b2b_second got=%h exp=%h", bus.Q, 16'h5A5A);
    end
  endtask

  task automatic test_sync_reset_pulse();
    drive(1'b0, 1'b1, 16'h1234);
    step();
    drive(1'b0, 1'b0, 16'hBEEF);
    #1 reset = 1'b1;
    #2;
    checks++;
    if (bus.Q !== 16'h1234) begin
      failures++;
      $display("FAIL reset_pulse_mid got=%h exp=%h", bus.Q, 16'h1234);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.Q !== 16'h1234) begin
      failures++;
      $display("FAIL reset_pulse_edge got=%h exp=%h", bus.Q, 16'h1234);
    end
  endtask

  // Random traffic with glitches between edges; only edge-time values may matter.
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 15) == 0);
      bus.en = 1'($urandom);
      bus.D  = W'($urandom);
      #1;
      reset  = 1'($urandom);
      bus.en = 1'($urandom);
      bus.D  = W'($urandom);
      #1;
      checks++;
      if (bus.Q !== exp_q) begin
        failures++;
        $display("FAIL rand_mid cyc=%0d got=%h exp=%h", i, bus.Q, exp_q);
      end
      reset  = ($urandom_range(0, 15) == 0);
      bus.en = 1'($urandom);
      bus.D  = W'($urandom);
      step();
      checks++;
      if (bus.Q !== exp_q || bus2.Q !== exp_q2) begin
        failures++;
        $display("FAIL rand_edge cyc=%0d got=%h/%h exp=%h/%h", i, bus.Q, bus2.Q, exp_q, exp_q2);
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    bus.en = 1'b0;
    bus.D  = '0;
    test_reset();
    test_release_hold();
    test_load();
    test_hold();
    test_reset_unknown();
    test_priority();
    test_back_to_back();
    test_sync_reset_pulse();
    test_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
